// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-port memory arbiter.
//   state_e      - arbiter FSM encoding (2-bit)
//   PORT_CORE/DMA- requester indices (core = 0, boot loader/DMA = 1)
//   RD_LAT_*     - legal range of the memory read latency parameter
//   CNT_W        - width of the read wait-state counter (covers RD_LAT_MAX)
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-macro signals of the arbiter.
//   slave  - arbiter side: takes req/we/addr/wdata per port and mem_rdata,
//            drives gnt/rvalid/rdata/busy and the memory command.
//   master - environment side (requesters plus memory macro).
interface mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way request picker.
//   req[1:0] - pending requests, last - port granted most recently,
//   fixed    - 1: port 0 always wins, 0: round-robin on ties.
//   valid    - any request pending, winner - selected port index.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic       valid,
    output logic       winner
);
    always_comb begin
        valid  = |req;
        winner = PORT_CORE;
        if (fixed)
            winner = req[0] ? PORT_CORE : PORT_DMA;
        else if (req == 2'b11)
            winner = ~last;       // tie goes to the port that did not win last
        else
            winner = req[1];      // single requester (or none, valid=0)
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the core (port 0) and
// the boot loader/DMA (port 1). One transaction in flight; reads wait RD_LAT
// cycles. All outputs are registered and computed from the next state, so a
// request sampled in IDLE (cycle 0) shows gnt/mem_en in cycle 1.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   bus          - request/response and memory-macro signals (slave side)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_arbiter: RD_LAT out of range 1..4");
    end

    state_e           state_q, state_d;
    logic             last_q, last_d, sel_q, sel_d, we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic             busy_q, busy_d, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [DW-1:0]    rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic             pick_valid, pick_winner;

    rr_pick2 u_pick (
        .req    ({bus.req1, bus.req0}),
        .last   (last_q),
        .fixed  (FIXED_PRIO != 0),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = ACCESS;
                    last_d      = pick_winner;
                    sel_d       = pick_winner;
                    we_d        = pick_winner ? bus.we1 : bus.we0;
                    mem_addr_d  = pick_winner ? bus.addr1 : bus.addr0;
                    mem_wdata_d = pick_winner ? bus.wdata1 : bus.wdata0;
                    // ACCESS-cycle outputs are loaded here so they are live in ACCESS
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_d;
                    gnt0_d      = (pick_winner == PORT_CORE);
                    gnt1_d      = (pick_winner == PORT_DMA);
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d   = DONE;
                    rvalid0_d = (sel_q == PORT_CORE);
                    rvalid1_d = (sel_q == PORT_DMA);
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(RD_LAT);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // cnt==1 is the cycle mem_rdata is valid (RD_LAT after mem_en)
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    rdata_d   = bus.mem_rdata;
                    rvalid0_d = (sel_q == PORT_CORE);
                    rvalid1_d = (sel_q == PORT_DMA);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= PORT_DMA;
            sel_q       <= PORT_CORE;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.busy      = busy_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench. Five arbiters share one broadcast stimulus:
//   inst 0: RD_LAT=1 round-robin, inst 1: RD_LAT=1 fixed priority,
//   inst 2..4: RD_LAT=2..4 round-robin. Each has its own memory model.
module tb_mem_arbiter;
    localparam int NI = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [9:0]  addr0 = 0, addr1 = 0;
    logic [31:0] wdata0 = 0, wdata1 = 0;

    logic [NI-1:0] gnt0_v, gnt1_v, rv0_v, rv1_v, busy_v, en_v, we_v;
    logic [31:0]   rdata_v [NI];
    logic [9:0]    maddr_v [NI];
    logic [31:0]   mwdata_v [NI];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] preload(input logic [9:0] a);
        return (a == 10'h004) ? 32'h0050_0113 : (32'hA500_0000 | 32'(a));
    endfunction

    function automatic int lat_of(input int i);
        return (i < 2) ? 1 : i;
    endfunction

    for (genvar i = 0; i < NI; i++) begin : g_inst
        localparam int LAT = (i < 2) ? 1 : i;
        localparam int FP  = (i == 1) ? 1 : 0;
        mem_arbiter_if #(.AW(10), .DW(32)) bus ();
        logic [31:0]   mem [1024];
        logic [1023:0] written;
        logic [31:0]   pipe [4];

        assign bus.req0 = req0;  assign bus.we0 = we0;
        assign bus.addr0 = addr0; assign bus.wdata0 = wdata0;
        assign bus.req1 = req1;  assign bus.we1 = we1;
        assign bus.addr1 = addr1; assign bus.wdata1 = wdata1;
        assign bus.mem_rdata = pipe[LAT-1];

        mem_arbiter #(.AW(10), .DW(32), .RD_LAT(LAT), .FIXED_PRIO(FP)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        // memory macro: data of a read appears LAT cycles after the mem_en cycle
        always @(posedge clock) begin
            if (reset) written <= '0;
            if (bus.mem_en && bus.mem_we) begin
                mem[bus.mem_addr]     <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end
            if (bus.mem_en && !bus.mem_we)
                pipe[0] <= written[bus.mem_addr] ? mem[bus.mem_addr] : preload(bus.mem_addr);
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end

        assign gnt0_v[i] = bus.gnt0;    assign gnt1_v[i] = bus.gnt1;
        assign rv0_v[i]  = bus.rvalid0; assign rv1_v[i]  = bus.rvalid1;
        assign busy_v[i] = bus.busy;    assign en_v[i]   = bus.mem_en;
        assign we_v[i]   = bus.mem_we;
        assign rdata_v[i]  = bus.rdata;
        assign maddr_v[i]  = bus.mem_addr;
        assign mwdata_v[i] = bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        req0 = 0; req1 = 0;
        repeat (n) tick();
    endtask

    // returns with reset just released: the current cycle is an IDLE sampling cycle
    task automatic do_reset();
        req0 = 0; req1 = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic chk_zero(input string tag, input int i);
        chk({tag, "_ctl"}, 32'({gnt0_v[i], gnt1_v[i], rv0_v[i], rv1_v[i],
                                busy_v[i], en_v[i], we_v[i]}), 32'h0);
        chk({tag, "_rdata"}, rdata_v[i], 32'h0);
        chk({tag, "_maddr"}, 32'(maddr_v[i]), 32'h0);
        chk({tag, "_mwdata"}, mwdata_v[i], 32'h0);
    endtask

    initial begin
        int g0 [4]; int g1 [4]; int n0; int n1;
        int rv_cyc [NI]; int en_cnt [NI]; logic [31:0] rd_at [NI];
        int cnt_a; int cnt_b; int cnt_c;

        // reset state
        #1;
        tick(); tick();
        chk_zero("reset", 0);
        chk_zero("reset_fp", 1);
        reset = 0;

        // single read, port 0, addr 0x004
        req0 = 1; we0 = 0; addr0 = 10'h004;
        tick();                                 // cycle 1
        chk("rd_gnt0", 32'(gnt0_v[0]), 1);
        chk("rd_gnt1", 32'(gnt1_v[0]), 0);
        chk("rd_en", 32'(en_v[0]), 1);
        chk("rd_we", 32'(we_v[0]), 0);
        chk("rd_addr", 32'(maddr_v[0]), 32'h004);
        req0 = 0;
        tick();                                 // cycle 2
        chk("rd_rv_early", 32'(rv0_v[0]), 0);
        chk("rd_en_once", 32'(en_v[0]), 0);
        tick();                                 // cycle 3
        chk("rd_rv0", 32'(rv0_v[0]), 1);
        chk("rd_data", rdata_v[0], 32'h0050_0113);
        chk("rd_busy3", 32'(busy_v[0]), 1);
        tick();                                 // cycle 4
        chk("rd_busy4", 32'(busy_v[0]), 0);
        chk("rd_rv_drop", 32'(rv0_v[0]), 0);
        idle(8);

        // single write, port 1, addr 0x3FF, then read back on port 0
        req1 = 1; we1 = 1; addr1 = 10'h3FF; wdata1 = 32'hDEAD_BEEF;
        tick();                                 // cycle 1
        chk("wr_gnt1", 32'(gnt1_v[0]), 1);
        chk("wr_en", 32'(en_v[0]), 1);
        chk("wr_we", 32'(we_v[0]), 1);
        chk("wr_addr", 32'(maddr_v[0]), 32'h3FF);
        chk("wr_wdata", mwdata_v[0], 32'hDEAD_BEEF);
        req1 = 0; we1 = 0;
        tick();                                 // cycle 2
        chk("wr_rv1", 32'(rv1_v[0]), 1);
        chk("wr_rv0", 32'(rv0_v[0]), 0);
        chk("wr_rdata_kept", rdata_v[0], 32'h0050_0113);
        idle(8);
        req0 = 1; we0 = 0; addr0 = 10'h3FF;
        tick();
        req0 = 0;
        tick(); tick();                         // cycle 3
        chk("wrrd_rv0", 32'(rv0_v[0]), 1);
        chk("wrrd_data", rdata_v[0], 32'hDEAD_BEEF);
        idle(8);

        // both requesting continuously: round-robin vs fixed priority
        do_reset();
        req0 = 1; we0 = 0; addr0 = 10'h020;
        req1 = 1; we1 = 0; addr1 = 10'h030;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 4; k++) begin g0[k] = -1; g1[k] = -1; end
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk("rr_excl_gnt", 32'(gnt0_v[0] & gnt1_v[0]), 0);
            chk("rr_excl_rv", 32'(rv0_v[0] & rv1_v[0]), 0);
            if ((gnt0_v[0] | gnt1_v[0]) && n0 < 4) begin g0[n0] = int'(gnt1_v[0]); n0++; end
            if ((gnt0_v[1] | gnt1_v[1]) && n1 < 4) begin g1[n1] = int'(gnt1_v[1]); n1++; end
        end
        req0 = 0; req1 = 0;
        chk("rr_cnt", 32'(n0), 4);
        chk("rr_order0", 32'(g0[0]), 0);
        chk("rr_order1", 32'(g0[1]), 1);
        chk("rr_order2", 32'(g0[2]), 0);
        chk("rr_order3", 32'(g0[3]), 1);
        chk("fp_cnt", 32'(n1), 4);
        chk("fp_order", 32'({g1[0] == 0, g1[1] == 0, g1[2] == 0, g1[3] == 0}), 32'hF);
        idle(8);

        // read latency sweep, addr 0x010
        do_reset();
        req0 = 1; we0 = 0; addr0 = 10'h010;
        for (int i = 0; i < NI; i++) begin rv_cyc[i] = -1; en_cnt[i] = 0; rd_at[i] = 0; end
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) req0 = 0;
            for (int i = 0; i < NI; i++) begin
                if (en_v[i]) en_cnt[i]++;
                if (rv0_v[i] && rv_cyc[i] < 0) begin rv_cyc[i] = c; rd_at[i] = rdata_v[i]; end
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("lat%0d_rv_cyc", lat_of(i)), 32'(rv_cyc[i]), 32'(2 + lat_of(i)));
            chk($sformatf("lat%0d_en_cnt", lat_of(i)), 32'(en_cnt[i]), 1);
            chk($sformatf("lat%0d_data", lat_of(i)), rd_at[i], 32'hA500_0010);
        end
        idle(4);

        // reset during the WAIT of a port-1 read
        do_reset();
        req1 = 1; we1 = 0; addr1 = 10'h055;
        tick();                                 // cycle 1 (ACCESS)
        chk("rst_gnt1", 32'(gnt1_v[0]), 1);
        req1 = 0;
        tick();                                 // cycle 2 (WAIT)
        reset = 1;
        tick();
        chk_zero("rst_mid", 0);
        reset = 0;
        req0 = 1; we0 = 0; addr0 = 10'h004;
        tick();
        chk("rst_req0_gnt", 32'(gnt0_v[0]), 1);
        req0 = 0;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rv1_v[0]) cnt_a++;
            if (rv0_v[0]) cnt_b++;
        end
        chk("rst_no_rv1", 32'(cnt_a), 0);
        chk("rst_rv0_once", 32'(cnt_b), 1);
        idle(4);

        // port-1 request pulsed only during a port-0 WAIT is ignored
        do_reset();
        req0 = 1; we0 = 0; addr0 = 10'h008;
        tick();                                 // cycle 1
        req0 = 0;
        tick();                                 // cycle 2 (WAIT)
        req1 = 1; we1 = 0; addr1 = 10'h077;
        tick();                                 // cycle 3 (DONE)
        req1 = 0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gnt1_v[0]) cnt_a++;
            if (en_v[0]) cnt_b++;
            if (gnt1_v[4]) cnt_c++;
        end
        chk("pulse_no_gnt1", 32'(cnt_a), 0);
        chk("pulse_no_mem", 32'(cnt_b), 0);
        chk("pulse_no_gnt1_lat4", 32'(cnt_c), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port 32-bit memory between two requesters: port 0 is the multicycle RV32I core's memory interface (fetch, load, store); port 1 is the boot loader/DMA.
- Sits between the core datapath's address/data muxes and the memory macro, replacing the direct core-to-memory connection.
- Serialises accesses and inserts wait states for a fixed read latency.
- Returns a per-port completion pulse, so the main controller stalls in its memory states until the pulse arrives.

Parameters:
- AW, 10, word-address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles after the enable cycle; legal range 1..4.
- FIXED_PRIO, 0. 0 selects round-robin. 1 makes port 0 always win.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req0  in  1  port 0 access request; held until gnt0
- we0  in  1  port 0 write enable, qualified by req0
- addr0  in  AW  port 0 word address
- wdata0  in  DW  port 0 write data
- req1, we1, addr1, wdata1  in  1/1/AW/DW  same roles for port 1
- gnt0, gnt1  out  1  one-cycle pulse: request accepted; requester may change inputs next cycle
- rvalid0, rvalid1  out  1  one-cycle completion pulse, for both reads and writes
- rdata  out  DW  read data, shared; valid when either rvalid is high
- busy  out  1  high in any state other than IDLE
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after the mem_en cycle

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Registered outputs: all outputs are registered. Reset value of every output is 0, including rdata.
- Internal reset state: state=IDLE, last=1 (so port 0 wins the first tie), wait counter=0.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Samples req0/req1. If neither is high, stay in IDLE.
  - Otherwise pick a winner and latch sel, we, addr, wdata from the winner. Next state is ACCESS.
  - Arbitration with FIXED_PRIO=0: if exactly one request is high, grant it. If both are high, grant the port whose index is not equal to last. Update last=winner.
  - Arbitration with FIXED_PRIO=1: port 0 wins whenever req0 is high. last is still updated.
- ACCESS:
  - Exactly one cycle: mem_en=1, mem_we=latched we, mem_addr/mem_wdata latched; gnt[sel]=1.
  - Write: next state is DONE.
  - Read: load counter=RD_LAT and go to WAIT.
- WAIT:
  - mem_en=0 and the counter decrements each cycle.
  - In the cycle the counter equals 1, capture mem_rdata into rdata and go to DONE.
  - WAIT lasts exactly RD_LAT cycles.
- DONE:
  - rvalid[sel]=1 for one cycle.
  - rdata holds the captured read value; rdata is unchanged after a write.
  - Next state is IDLE. There is no arbitration in DONE.
- Latency, with cycle 0 being the IDLE cycle that samples the request:
  - gnt at cycle 1.
  - Write: rvalid at cycle 2. Next request sampled at cycle 3.
  - Read: rvalid at cycle 2+RD_LAT. Next request sampled at cycle 3+RD_LAT.
- Handshake rules:
  - Requests are sampled only in IDLE. A req that drops before it is sampled is ignored.
  - A req still high in the IDLE cycle after rvalid is treated as a new request.
  - gnt and rvalid are never asserted for both ports in the same cycle.
  - At most one transaction is in flight.
- Simultaneous requests from both ports in consecutive transactions alternate 0,1,0,1 when FIXED_PRIO=0.
- Reset mid-operation:
  - At the reset edge: state returns to IDLE, all outputs clear, the in-flight transaction is dropped, and no rvalid is issued.
  - A write whose ACCESS cycle coincides with the reset-asserted cycle still completes, because mem_we is already registered high for that cycle.
- Widths: mem_addr and mem_wdata are passed through unmodified. No byte enables (word accesses only).

Decomposition:
- Shared package/include holds:
  - State encodings: IDLE=0, ACCESS=1, WAIT=2, DONE=3, 2-bit.
  - Port index constants: PORT_CORE=0, PORT_DMA=1.
  - RD_LAT legal-range constants, checked by an elaboration-time assertion.
- One natural sub-module: rr_pick2.
  - Combinational 2-way picker.
  - Inputs: req[1:0], last, fixed.
  - Outputs: valid, winner.

Test Plan:
- Single read, port 0, addr=0x004, memory word 0x00500113, RD_LAT=1: gnt0 at cycle 1, mem_en=1/mem_we=0 at cycle 1, rvalid0=1 and rdata=0x00500113 at cycle 3, busy low at cycle 4.
- Single write, port 1, addr=0x3FF, wdata=0xDEADBEEF: mem_we=1, mem_addr=0x3FF at cycle 1; rvalid1 at cycle 2; a follow-up read of 0x3FF returns 0xDEADBEEF.
- Both req held high for 4 transactions, FIXED_PRIO=0, after reset: grant order is 0,1,0,1. With FIXED_PRIO=1 the order is 0,0,0,0 and port 1 is starved.
- Sweep RD_LAT=1..4, read 0x010: rvalid at cycle 2+RD_LAT; mem_en high for exactly one cycle per transaction.
- Reset asserted during the WAIT of a port 1 read: next cycle all outputs are 0, no rvalid1 appears, and a subsequent req0 is granted at cycle 1.
- req1 pulsed for one cycle during a port 0 WAIT and then dropped: no gnt1 and no memory access for port 1.
